// File: rtl/pcie_axi_window_gate.sv
// pcie_axi_window_gate: AXI4 gate in front of the PCIe bridge s_axi port.
// Forwards in-window requests with a rebased address and caps outstanding
// bursts per direction. Out-of-window requests, and any request made while
// the link is down, are answered locally with SLVERR/DECERR.
// Build macro PCIE_WIN_ERR_CNT_EN adds a saturating error-burst counter
// (err_count) with a synchronous clear (err_clear).
module pcie_axi_window_gate #(
    parameter int ID_W       = 4,
    parameter int DATA_W     = 64,
    parameter int ADDR_IN_W  = 38,
    parameter int ADDR_OUT_W = 32,
    parameter logic [ADDR_IN_W-1:0] WINDOW_BASE = 38'h2000_0000,
    parameter logic [ADDR_IN_W-1:0] WINDOW_SIZE = 38'h4000_0000,
    parameter int MAX_OUTST  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  link_up,
`ifdef PCIE_WIN_ERR_CNT_EN
    input  logic                  err_clear,
    output logic [15:0]           err_count,
`endif
    // upstream write address
    input  logic                  in_aw_valid,
    output logic                  in_aw_ready,
    input  logic [ID_W-1:0]       in_aw_bits_id,
    input  logic [ADDR_IN_W-1:0]  in_aw_bits_addr,
    input  logic [7:0]            in_aw_bits_len,
    input  logic [2:0]            in_aw_bits_size,
    input  logic [1:0]            in_aw_bits_burst,
    // upstream write data
    input  logic                  in_w_valid,
    output logic                  in_w_ready,
    input  logic [DATA_W-1:0]     in_w_bits_data,
    input  logic [DATA_W/8-1:0]   in_w_bits_strb,
    input  logic                  in_w_bits_last,
    // upstream write response
    output logic                  in_b_valid,
    input  logic                  in_b_ready,
    output logic [ID_W-1:0]       in_b_bits_id,
    output logic [1:0]            in_b_bits_resp,
    // upstream read address
    input  logic                  in_ar_valid,
    output logic                  in_ar_ready,
    input  logic [ID_W-1:0]       in_ar_bits_id,
    input  logic [ADDR_IN_W-1:0]  in_ar_bits_addr,
    input  logic [7:0]            in_ar_bits_len,
    input  logic [2:0]            in_ar_bits_size,
    input  logic [1:0]            in_ar_bits_burst,
    // upstream read data
    output logic                  in_r_valid,
    input  logic                  in_r_ready,
    output logic [ID_W-1:0]       in_r_bits_id,
    output logic [DATA_W-1:0]     in_r_bits_data,
    output logic [1:0]            in_r_bits_resp,
    output logic                  in_r_bits_last,
    // bridge write address
    output logic                  out_aw_valid,
    input  logic                  out_aw_ready,
    output logic [ID_W-1:0]       out_aw_bits_id,
    output logic [ADDR_OUT_W-1:0] out_aw_bits_addr,
    output logic [7:0]            out_aw_bits_len,
    output logic [2:0]            out_aw_bits_size,
    output logic [1:0]            out_aw_bits_burst,
    // bridge write data
    output logic                  out_w_valid,
    input  logic                  out_w_ready,
    output logic [DATA_W-1:0]     out_w_bits_data,
    output logic [DATA_W/8-1:0]   out_w_bits_strb,
    output logic                  out_w_bits_last,
    // bridge write response
    input  logic                  out_b_valid,
    output logic                  out_b_ready,
    input  logic [ID_W-1:0]       out_b_bits_id,
    input  logic [1:0]            out_b_bits_resp,
    // bridge read address
    output logic                  out_ar_valid,
    input  logic                  out_ar_ready,
    output logic [ID_W-1:0]       out_ar_bits_id,
    output logic [ADDR_OUT_W-1:0] out_ar_bits_addr,
    output logic [7:0]            out_ar_bits_len,
    output logic [2:0]            out_ar_bits_size,
    output logic [1:0]            out_ar_bits_burst,
    // bridge read data
    input  logic                  out_r_valid,
    output logic                  out_r_ready,
    input  logic [ID_W-1:0]       out_r_bits_id,
    input  logic [DATA_W-1:0]     out_r_bits_data,
    input  logic [1:0]            out_r_bits_resp,
    input  logic                  out_r_bits_last
);

    localparam int CNT_W = 8;
    // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
    localparam logic [ADDR_IN_W:0] WIN_END = {1'b0, WINDOW_BASE} + {1'b0, WINDOW_SIZE};

    typedef enum logic [1:0] {W_IDLE, W_PASS, W_DRAIN, W_ERRB} wr_state_t;
    typedef enum logic       {R_IDLE, R_ERR}                   rd_state_t;

    function automatic logic win_hit(input logic [ADDR_IN_W-1:0] a);
        return ({1'b0, a} >= {1'b0, WINDOW_BASE}) && ({1'b0, a} < WIN_END);
    endfunction

    function automatic logic [ADDR_OUT_W-1:0] xlate(input logic [ADDR_IN_W-1:0] a);
        return ADDR_OUT_W'(a - WINDOW_BASE);
    endfunction

    // Link down dominates: a miss while the link is down still reports SLVERR.
    function automatic logic [1:0] err_code(input logic lnk);
        return lnk ? 2'b11 : 2'b10;
    endfunction

    // Outstanding count update; a decrement at zero is ignored rather than wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec)               return c + 1'b1;
        if (dec && !inc && c != '0)    return c - 1'b1;
        return c;
    endfunction

    wr_state_t         wr_state, wr_state_n;
    rd_state_t         rd_state, rd_state_n;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;
    logic              wr_inc, wr_dec, wr_err_acc;
    logic              rd_inc, rd_dec, rd_err_acc;
    logic [ID_W-1:0]   b_id_q, r_id_q;
    logic [1:0]        b_code_q, r_code_q;
    logic [7:0]        r_len_q, r_beat_q;
    logic              r_last;
    logic              aw_fwd, ar_fwd, wr_room, rd_room;

    assign aw_fwd  = win_hit(in_aw_bits_addr) && link_up;
    assign ar_fwd  = win_hit(in_ar_bits_addr) && link_up;
    assign wr_room = wr_cnt < CNT_W'(MAX_OUTST);
    assign rd_room = rd_cnt < CNT_W'(MAX_OUTST);
    assign r_last  = (r_beat_q == r_len_q);

    // Request payloads pass straight through; only the handshakes are gated.
    assign out_aw_bits_id    = in_aw_bits_id;
    assign out_aw_bits_addr  = xlate(in_aw_bits_addr);
    assign out_aw_bits_len   = in_aw_bits_len;
    assign out_aw_bits_size  = in_aw_bits_size;
    assign out_aw_bits_burst = in_aw_bits_burst;
    assign out_w_bits_data   = in_w_bits_data;
    assign out_w_bits_strb   = in_w_bits_strb;
    assign out_w_bits_last   = in_w_bits_last;
    assign out_ar_bits_id    = in_ar_bits_id;
    assign out_ar_bits_addr  = xlate(in_ar_bits_addr);
    assign out_ar_bits_len   = in_ar_bits_len;
    assign out_ar_bits_size  = in_ar_bits_size;
    assign out_ar_bits_burst = in_ar_bits_burst;

    // Write-side next state and channel gating; everything held quiet during reset.
    always_comb begin
        wr_state_n     = wr_state;
        out_aw_valid   = 1'b0;
        in_aw_ready    = 1'b0;
        out_w_valid    = 1'b0;
        in_w_ready     = 1'b0;
        in_b_valid     = out_b_valid;
        in_b_bits_id   = out_b_bits_id;
        in_b_bits_resp = out_b_bits_resp;
        out_b_ready    = in_b_ready;
        wr_inc         = 1'b0;
        wr_err_acc     = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (aw_fwd) begin
                    if (wr_room) begin
                        out_aw_valid = in_aw_valid;
                        in_aw_ready  = out_aw_ready;
                        if (in_aw_valid && out_aw_ready) begin
                            wr_inc     = 1'b1;
                            wr_state_n = W_PASS;
                        end
                    end
                end else begin
                    // Wait for forwarded writes to retire so the local B cannot overtake them.
                    in_aw_ready = (wr_cnt == '0);
                    if (in_aw_valid && wr_cnt == '0) begin
                        wr_err_acc = 1'b1;
                        wr_state_n = W_DRAIN;
                    end
                end
            end
            W_PASS: begin
                out_w_valid = in_w_valid;
                in_w_ready  = out_w_ready;
                if (in_w_valid && out_w_ready && in_w_bits_last) wr_state_n = W_IDLE;
            end
            W_DRAIN: begin
                in_w_ready = 1'b1;
                if (in_w_valid && in_w_bits_last) wr_state_n = W_ERRB;
            end
            W_ERRB: begin
                in_b_valid     = 1'b1;
                in_b_bits_id   = b_id_q;
                in_b_bits_resp = b_code_q;
                out_b_ready    = 1'b0;
                if (in_b_ready) wr_state_n = W_IDLE;
            end
            default: wr_state_n = W_IDLE;
        endcase
        if (reset) begin
            out_aw_valid = 1'b0;
            in_aw_ready  = 1'b0;
            out_w_valid  = 1'b0;
            in_w_ready   = 1'b0;
            in_b_valid   = 1'b0;
            out_b_ready  = 1'b0;
        end
    end

    // Read-side next state and channel gating; local beats replace the bridge in R_ERR.
    always_comb begin
        rd_state_n     = rd_state;
        out_ar_valid   = 1'b0;
        in_ar_ready    = 1'b0;
        in_r_valid     = out_r_valid;
        in_r_bits_id   = out_r_bits_id;
        in_r_bits_data = out_r_bits_data;
        in_r_bits_resp = out_r_bits_resp;
        in_r_bits_last = out_r_bits_last;
        out_r_ready    = in_r_ready;
        rd_inc         = 1'b0;
        rd_err_acc     = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (ar_fwd) begin
                    if (rd_room) begin
                        out_ar_valid = in_ar_valid;
                        in_ar_ready  = out_ar_ready;
                        rd_inc       = in_ar_valid && out_ar_ready;
                    end
                end else begin
                    in_ar_ready = (rd_cnt == '0);
                    if (in_ar_valid && rd_cnt == '0) begin
                        rd_err_acc = 1'b1;
                        rd_state_n = R_ERR;
                    end
                end
            end
            R_ERR: begin
                in_r_valid     = 1'b1;
                in_r_bits_id   = r_id_q;
                in_r_bits_data = '0;
                in_r_bits_resp = r_code_q;
                in_r_bits_last = r_last;
                out_r_ready    = 1'b0;
                if (in_r_ready && r_last) rd_state_n = R_IDLE;
            end
            default: rd_state_n = R_IDLE;
        endcase
        if (reset) begin
            out_ar_valid = 1'b0;
            in_ar_ready  = 1'b0;
            in_r_valid   = 1'b0;
            out_r_ready  = 1'b0;
        end
    end

    assign wr_dec = out_b_valid && out_b_ready;
    assign rd_dec = out_r_valid && out_r_ready && out_r_bits_last;

    // Write FSM state, outstanding count and latched local-B response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            b_id_q   <= '0;
            b_code_q <= '0;
        end else begin
            wr_state <= wr_state_n;
            wr_cnt   <= cnt_next(wr_cnt, wr_inc, wr_dec);
            if (wr_err_acc) begin
                b_id_q   <= in_aw_bits_id;
                b_code_q <= err_code(link_up);
            end
        end
    end

    // Read FSM state, outstanding count and local-R burst tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            r_id_q   <= '0;
            r_code_q <= '0;
            r_len_q  <= '0;
            r_beat_q <= '0;
        end else begin
            rd_state <= rd_state_n;
            rd_cnt   <= cnt_next(rd_cnt, rd_inc, rd_dec);
            if (rd_err_acc) begin
                r_id_q   <= in_ar_bits_id;
                r_code_q <= err_code(link_up);
                r_len_q  <= in_ar_bits_len;
                r_beat_q <= '0;
            end else if (rd_state == R_ERR && in_r_ready) begin
                r_beat_q <= r_beat_q + 1'b1;
            end
        end
    end

    // A bridge completion with nothing outstanding is a protocol violation.
    assert property (@(posedge clock) disable iff (reset) !(wr_dec && wr_cnt == '0));
    assert property (@(posedge clock) disable iff (reset) !(rd_dec && rd_cnt == '0));

`ifdef PCIE_WIN_ERR_CNT_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic       b_err_done, r_err_done;
    logic [1:0] err_evt;

    assign b_err_done = (wr_state == W_ERRB) && in_b_ready;
    assign r_err_done = (rd_state == R_ERR) && in_r_ready && r_last;
    assign err_evt    = 2'(b_err_done) + 2'(r_err_done);

    // Error-burst counter: clear has priority over a same-cycle increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          err_count <= '0;
        else if (err_clear) err_count <= '0;
        else                err_count <= sat_add(err_count, err_evt);
    end
`endif

endmodule

// File: tb/tb_pcie_axi_window_gate.sv
// Directed, table-driven bench for pcie_axi_window_gate (MAX_OUTST=2 instance).
`define CHK(nm, a, e) check(nm, 64'(a), 64'(e))
module tb_pcie_axi_window_gate;
    localparam int ID_W = 4, DATA_W = 64, AI = 38, AO = 32;

    logic clock = 1'b0, reset = 1'b1, link_up = 1'b0;
    logic err_clear = 1'b0;
    logic [15:0] err_count;
    logic in_aw_valid = 0, in_aw_ready; logic [ID_W-1:0] in_aw_bits_id = '0;
    logic [AI-1:0] in_aw_bits_addr = '0; logic [7:0] in_aw_bits_len = '0;
    logic [2:0] in_aw_bits_size = 3'd3; logic [1:0] in_aw_bits_burst = 2'd1;
    logic in_w_valid = 0, in_w_ready; logic [DATA_W-1:0] in_w_bits_data = '0;
    logic [DATA_W/8-1:0] in_w_bits_strb = '1; logic in_w_bits_last = 0;
    logic in_b_valid, in_b_ready = 0; logic [ID_W-1:0] in_b_bits_id; logic [1:0] in_b_bits_resp;
    logic in_ar_valid = 0, in_ar_ready; logic [ID_W-1:0] in_ar_bits_id = '0;
    logic [AI-1:0] in_ar_bits_addr = '0; logic [7:0] in_ar_bits_len = '0;
    logic [2:0] in_ar_bits_size = 3'd3; logic [1:0] in_ar_bits_burst = 2'd1;
    logic in_r_valid, in_r_ready = 0; logic [ID_W-1:0] in_r_bits_id;
    logic [DATA_W-1:0] in_r_bits_data; logic [1:0] in_r_bits_resp; logic in_r_bits_last;
    logic out_aw_valid, out_aw_ready = 0; logic [ID_W-1:0] out_aw_bits_id;
    logic [AO-1:0] out_aw_bits_addr; logic [7:0] out_aw_bits_len;
    logic [2:0] out_aw_bits_size; logic [1:0] out_aw_bits_burst;
    logic out_w_valid, out_w_ready = 0; logic [DATA_W-1:0] out_w_bits_data;
    logic [DATA_W/8-1:0] out_w_bits_strb; logic out_w_bits_last;
    logic out_b_valid = 0, out_b_ready; logic [ID_W-1:0] out_b_bits_id = '0; logic [1:0] out_b_bits_resp = '0;
    logic out_ar_valid, out_ar_ready = 0; logic [ID_W-1:0] out_ar_bits_id;
    logic [AO-1:0] out_ar_bits_addr; logic [7:0] out_ar_bits_len;
    logic [2:0] out_ar_bits_size; logic [1:0] out_ar_bits_burst;
    logic out_r_valid = 0, out_r_ready; logic [ID_W-1:0] out_r_bits_id = '0;
    logic [DATA_W-1:0] out_r_bits_data = '0; logic [1:0] out_r_bits_resp = '0; logic out_r_bits_last = 0;

    pcie_axi_window_gate #(.MAX_OUTST(2)) dut (
        .clock(clock), .reset(reset), .link_up(link_up),
`ifdef PCIE_WIN_ERR_CNT_EN
        .err_clear(err_clear), .err_count(err_count),
`endif
        .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready), .in_aw_bits_id(in_aw_bits_id),
        .in_aw_bits_addr(in_aw_bits_addr), .in_aw_bits_len(in_aw_bits_len),
        .in_aw_bits_size(in_aw_bits_size), .in_aw_bits_burst(in_aw_bits_burst),
        .in_w_valid(in_w_valid), .in_w_ready(in_w_ready), .in_w_bits_data(in_w_bits_data),
        .in_w_bits_strb(in_w_bits_strb), .in_w_bits_last(in_w_bits_last),
        .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_bits_id(in_b_bits_id),
        .in_b_bits_resp(in_b_bits_resp),
        .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready), .in_ar_bits_id(in_ar_bits_id),
        .in_ar_bits_addr(in_ar_bits_addr), .in_ar_bits_len(in_ar_bits_len),
        .in_ar_bits_size(in_ar_bits_size), .in_ar_bits_burst(in_ar_bits_burst),
        .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r_bits_id(in_r_bits_id),
        .in_r_bits_data(in_r_bits_data), .in_r_bits_resp(in_r_bits_resp), .in_r_bits_last(in_r_bits_last),
        .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready), .out_aw_bits_id(out_aw_bits_id),
        .out_aw_bits_addr(out_aw_bits_addr), .out_aw_bits_len(out_aw_bits_len),
        .out_aw_bits_size(out_aw_bits_size), .out_aw_bits_burst(out_aw_bits_burst),
        .out_w_valid(out_w_valid), .out_w_ready(out_w_ready), .out_w_bits_data(out_w_bits_data),
        .out_w_bits_strb(out_w_bits_strb), .out_w_bits_last(out_w_bits_last),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_bits_id(out_b_bits_id),
        .out_b_bits_resp(out_b_bits_resp),
        .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready), .out_ar_bits_id(out_ar_bits_id),
        .out_ar_bits_addr(out_ar_bits_addr), .out_ar_bits_len(out_ar_bits_len),
        .out_ar_bits_size(out_ar_bits_size), .out_ar_bits_burst(out_ar_bits_burst),
        .out_r_valid(out_r_valid), .out_r_ready(out_r_ready), .out_r_bits_id(out_r_bits_id),
        .out_r_bits_data(out_r_bits_data), .out_r_bits_resp(out_r_bits_resp), .out_r_bits_last(out_r_bits_last)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic          is_wr;
        logic          link;
        logic [3:0]    id;
        logic [AI-1:0] addr;
        logic [7:0]    len;
        logic          fwd;
        logic [AO-1:0] out_addr;
        logic [1:0]    resp;   // bridge response when forwarded, local code otherwise
    } vec_t;

    vec_t vecs [10];

    task automatic run_write(input vec_t v, input int n);
        link_up = v.link;
        in_aw_valid = 1; in_aw_bits_id = v.id; in_aw_bits_addr = v.addr; in_aw_bits_len = v.len;
        out_aw_ready = 1;
        #1;
        `CHK($sformatf("v%0d_out_aw_valid", n), out_aw_valid, v.fwd);
        `CHK($sformatf("v%0d_in_aw_ready", n), in_aw_ready, 1'b1);
        if (v.fwd) `CHK($sformatf("v%0d_out_aw_addr", n), out_aw_bits_addr, v.out_addr);
        tick();
        in_aw_valid = 0; out_aw_ready = 0;
        for (int b = 0; b <= int'(v.len); b++) begin
            in_w_valid = 1; in_w_bits_data = {32'hD000_0000 + 32'(n), 32'(b)};
            in_w_bits_last = (b == int'(v.len)); out_w_ready = 1;
            #1;
            `CHK($sformatf("v%0d_w%0d_out_valid", n, b), out_w_valid, v.fwd);
            checks++;
            if (in_w_ready !== 1'b1) begin
                errors++;
                $display("FAIL v%0d_w%0d_in_ready actual=%0h required=1", n, b, in_w_ready);
            end
            if (v.fwd) `CHK($sformatf("v%0d_w%0d_data", n, b), out_w_bits_data, {32'hD000_0000 + 32'(n), 32'(b)});
            tick();
        end
        in_w_valid = 0; in_w_bits_last = 0; out_w_ready = 0;
        #1;
        if (v.fwd) begin
            `CHK($sformatf("v%0d_b_early", n), in_b_valid, 1'b0);
            out_b_valid = 1; out_b_bits_id = v.id; out_b_bits_resp = v.resp; in_b_ready = 1;
            #1;
            `CHK($sformatf("v%0d_out_b_ready", n), out_b_ready, 1'b1);
        end else begin
            `CHK($sformatf("v%0d_out_b_ready", n), out_b_ready, 1'b0);
            in_b_ready = 1;
        end
        `CHK($sformatf("v%0d_b_valid", n), in_b_valid, 1'b1);
        `CHK($sformatf("v%0d_b_id", n), in_b_bits_id, v.id);
        `CHK($sformatf("v%0d_b_resp", n), in_b_bits_resp, v.resp);
        tick();
        out_b_valid = 0; in_b_ready = 0;
        #1;
        `CHK($sformatf("v%0d_b_done", n), in_b_valid, 1'b0);
    endtask

    task automatic run_read(input vec_t v, input int n);
        logic [DATA_W-1:0] exp_data;
        link_up = v.link;
        in_ar_valid = 1; in_ar_bits_id = v.id; in_ar_bits_addr = v.addr; in_ar_bits_len = v.len;
        out_ar_ready = 1;
        #1;
        `CHK($sformatf("v%0d_out_ar_valid", n), out_ar_valid, v.fwd);
        `CHK($sformatf("v%0d_in_ar_ready", n), in_ar_ready, 1'b1);
        if (v.fwd) `CHK($sformatf("v%0d_out_ar_addr", n), out_ar_bits_addr, v.out_addr);
        tick();
        in_ar_valid = 0; out_ar_ready = 0;
        for (int b = 0; b <= int'(v.len); b++) begin
            exp_data = v.fwd ? {32'hA500_0000 + 32'(n), 32'(b)} : '0;
            if (v.fwd) begin
                out_r_valid = 1; out_r_bits_id = v.id; out_r_bits_data = exp_data;
                out_r_bits_resp = v.resp; out_r_bits_last = (b == int'(v.len));
            end
            in_r_ready = 1;
            #1;
            checks++;
            if (in_r_valid !== 1'b1) begin
                errors++;
                $display("FAIL v%0d_r%0d_valid actual=%0h required=1", n, b, in_r_valid);
            end
            `CHK($sformatf("v%0d_r%0d_id", n, b), in_r_bits_id, v.id);
            `CHK($sformatf("v%0d_r%0d_data", n, b), in_r_bits_data, exp_data);
            `CHK($sformatf("v%0d_r%0d_resp", n, b), in_r_bits_resp, v.resp);
            `CHK($sformatf("v%0d_r%0d_last", n, b), in_r_bits_last, (b == int'(v.len)));
            `CHK($sformatf("v%0d_r%0d_out_ready", n, b), out_r_ready, v.fwd);
            tick();
        end
        out_r_valid = 0; out_r_bits_last = 0; in_r_ready = 0;
        #1;
        `CHK($sformatf("v%0d_r_done", n), in_r_valid, 1'b0);
    endtask

    task automatic err_read_once(input logic clr);
        link_up = 1; in_ar_valid = 1; in_ar_bits_addr = '0; in_ar_bits_len = 0;
        tick();
        in_ar_valid = 0; in_r_ready = 1; err_clear = clr;
        tick();
        in_r_ready = 0; err_clear = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        //            wr    link  id     addr              len   fwd   out_addr        resp
        vecs[0] = '{1'b1, 1'b1, 4'd3, 38'h00_2000_1000, 8'd3, 1'b1, 32'h0000_1000, 2'b00};
        vecs[1] = '{1'b0, 1'b1, 4'd5, 38'h00_1000_0000, 8'd2, 1'b0, 32'h0,         2'b11};
        vecs[2] = '{1'b1, 1'b0, 4'd2, 38'h00_2000_0000, 8'd1, 1'b0, 32'h0,         2'b10};
        vecs[3] = '{1'b0, 1'b1, 4'd7, 38'h00_5FFF_FFF8, 8'd0, 1'b1, 32'h3FFF_FFF8, 2'b00};
        vecs[4] = '{1'b1, 1'b1, 4'd1, 38'h00_6000_0000, 8'd0, 1'b0, 32'h0,         2'b11};
        vecs[5] = '{1'b0, 1'b1, 4'd9, 38'h00_1FFF_FFFF, 8'd1, 1'b0, 32'h0,         2'b11};
        vecs[6] = '{1'b0, 1'b0, 4'd4, 38'h00_3000_0000, 8'd0, 1'b0, 32'h0,         2'b10};
        vecs[7] = '{1'b1, 1'b1, 4'hF, 38'h20_2000_0000, 8'd0, 1'b0, 32'h0,         2'b11};
        vecs[8] = '{1'b0, 1'b1, 4'd6, 38'h00_2000_0000, 8'd1, 1'b1, 32'h0000_0000, 2'b00};
        vecs[9] = '{1'b1, 1'b1, 4'd8, 38'h00_5000_0040, 8'd0, 1'b1, 32'h3000_0040, 2'b10};

        // Reset: every valid/ready toward either side stays low even with traffic presented.
        link_up = 1; in_aw_valid = 1; in_aw_bits_addr = 38'h2000_0000; out_aw_ready = 1;
        in_ar_valid = 1; in_ar_bits_addr = 38'h2000_0000; out_ar_ready = 1;
        in_w_valid = 1; out_w_ready = 1; out_b_valid = 1; out_r_valid = 1;
        tick(); tick();
        `CHK("rst_out_aw_valid", out_aw_valid, 1'b0);
        `CHK("rst_in_aw_ready", in_aw_ready, 1'b0);
        `CHK("rst_out_ar_valid", out_ar_valid, 1'b0);
        `CHK("rst_in_ar_ready", in_ar_ready, 1'b0);
        `CHK("rst_in_w_ready", in_w_ready, 1'b0);
        `CHK("rst_out_w_valid", out_w_valid, 1'b0);
        `CHK("rst_in_b_valid", in_b_valid, 1'b0);
        `CHK("rst_in_r_valid", in_r_valid, 1'b0);
        in_aw_valid = 0; out_aw_ready = 0; in_ar_valid = 0; out_ar_ready = 0;
        in_w_valid = 0; out_w_ready = 0; out_b_valid = 0; out_r_valid = 0;
        reset = 0;
`ifdef PCIE_WIN_ERR_CNT_EN
        #1 `CHK("rst_err_count", err_count, 16'd0);
`endif
        tick();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) run_write(vecs[i], i);
            else               run_read(vecs[i], i);
        end

        // Outstanding read cap of 2, release on the first R last, and inc+dec in one cycle.
        tick();
        link_up = 1; out_ar_ready = 1; in_ar_valid = 1; in_ar_bits_addr = 38'h2000_0100; in_ar_bits_len = 0;
        for (int i = 0; i < 2; i++) begin
            in_ar_bits_id = 4'(i);
            #1 `CHK($sformatf("cap_ar%0d_ready", i), in_ar_ready, 1'b1);
            tick();
        end
        in_ar_bits_id = 4'd2;
        #1;
        `CHK("cap_ar2_stall", in_ar_ready, 1'b0);
        `CHK("cap_ar2_no_fwd", out_ar_valid, 1'b0);
        tick();
        out_r_valid = 1; out_r_bits_last = 1; out_r_bits_id = 4'd0; in_r_ready = 1;
        #1;
        `CHK("cap_ar2_stall_dec_cycle", in_ar_ready, 1'b0);
        `CHK("cap_r0_pass", in_r_valid, 1'b1);
        tick();
        out_r_valid = 0;
        #1 `CHK("cap_ar2_release", in_ar_ready, 1'b1);
        tick();                              // AR2 accepted: count 2
        in_ar_valid = 0;
        out_r_valid = 1;
        tick();                              // one R last retires: count 1
        in_ar_valid = 1; in_ar_bits_id = 4'd3;
        #1 `CHK("simul_ar3_ready", in_ar_ready, 1'b1);
        tick();                              // AR accept and R last together: count stays 1
        out_r_valid = 0; in_ar_bits_id = 4'd4;
        #1 `CHK("simul_ar4_ready", in_ar_ready, 1'b1);
        tick();                              // count 2
        in_ar_bits_id = 4'd5;
        #1 `CHK("simul_ar5_stall", in_ar_ready, 1'b0);
        in_ar_valid = 0; out_r_valid = 1;
        tick(); tick();                      // drain both
        out_r_valid = 0; out_r_bits_last = 0; in_r_ready = 0;
        in_ar_valid = 1; in_ar_bits_addr = 38'h0;
        #1 `CHK("drained_err_ar_ready", in_ar_ready, 1'b1);
        in_ar_valid = 0; out_ar_ready = 0;

        // Forwarded write outstanding, link drops mid-burst, then an error AW waits for its B.
        tick();
        link_up = 1; in_aw_valid = 1; in_aw_bits_id = 4'd6; in_aw_bits_addr = 38'h2000_0200;
        in_aw_bits_len = 0; out_aw_ready = 1;
        tick();
        in_aw_valid = 0; out_aw_ready = 0; link_up = 0;
        in_w_valid = 1; in_w_bits_last = 1; out_w_ready = 1;
        #1 `CHK("linkdrop_w_fwd", out_w_valid, 1'b1);
        tick();
        in_w_valid = 0; in_w_bits_last = 0; out_w_ready = 0;
        in_aw_valid = 1; in_aw_bits_id = 4'd9; in_aw_bits_addr = 38'h2000_0300;
        #1;
        `CHK("hold_aw_ready", in_aw_ready, 1'b0);
        `CHK("hold_aw_no_fwd", out_aw_valid, 1'b0);
        tick();
        out_b_valid = 1; out_b_bits_id = 4'd6; out_b_bits_resp = 2'b00; in_b_ready = 1;
        #1;
        `CHK("hold_fwd_b_id", in_b_bits_id, 4'd6);
        `CHK("hold_aw_ready_b_cycle", in_aw_ready, 1'b0);
        tick();
        out_b_valid = 0; in_b_ready = 0;
        #1 `CHK("hold_aw_release", in_aw_ready, 1'b1);
        tick();
        in_aw_valid = 0; in_w_valid = 1; in_w_bits_last = 1;
        #1;
        `CHK("hold_drain_ready", in_w_ready, 1'b1);
        `CHK("hold_drain_no_fwd", out_w_valid, 1'b0);
        tick();
        in_w_valid = 0; in_w_bits_last = 0;
        #1;
        `CHK("hold_errb_valid", in_b_valid, 1'b1);
        `CHK("hold_errb_id", in_b_bits_id, 4'd9);
        `CHK("hold_errb_resp", in_b_bits_resp, 2'b10);
        in_b_ready = 1;
        tick();
        in_b_ready = 0;

`ifdef PCIE_WIN_ERR_CNT_EN
        // Six error bursts from the table plus the held-off write.
        `CHK("errcnt_total", err_count, 16'd7);
        err_clear = 1; tick(); err_clear = 0;
        `CHK("errcnt_clear", err_count, 16'd0);
        err_read_once(1'b0); err_read_once(1'b0); err_read_once(1'b0);
        `CHK("errcnt_three", err_count, 16'd3);
        err_read_once(1'b1);
        `CHK("errcnt_clear_wins", err_count, 16'd0);
        force dut.err_count = 16'hFFFF;
        tick();
        release dut.err_count;
        err_read_once(1'b0);
        `CHK("errcnt_saturate", err_count, 16'hFFFF);
`endif

        // Reset in the middle of a local read burst abandons it.
        link_up = 1; in_ar_valid = 1; in_ar_bits_id = 4'd2; in_ar_bits_addr = 38'h0; in_ar_bits_len = 3;
        tick();
        in_ar_valid = 0;
        #1 `CHK("midrst_r_active", in_r_valid, 1'b1);
        reset = 1;
        #1 `CHK("midrst_r_in_reset", in_r_valid, 1'b0);
        tick();
        reset = 0;
        tick();
        `CHK("midrst_r_abandoned", in_r_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
